// File: rtl/sgmii_an_ctrl_if.sv
// PCS-facing bundle of the SGMII auto-negotiation controller: received /C/ and /I/ indications in,
// xmit mode and transmit config word out. master = controller side, slave = PCS side.
interface sgmii_an_ctrl_if;
  logic        i_RxConfigValid;
  logic [15:0] i16_RxConfigReg;
  logic        i_RxIdleValid;
  logic [2:0]  o3_Xmit;
  logic [15:0] o16_TxConfigReg;

  modport master (
    input  i_RxConfigValid, i16_RxConfigReg, i_RxIdleValid,
    output o3_Xmit, o16_TxConfigReg
  );

  modport slave (
    output i_RxConfigValid, i16_RxConfigReg, i_RxIdleValid,
    input  o3_Xmit, o16_TxConfigReg
  );
endinterface

// File: rtl/sgmii_an_ctrl.sv
// SGMII / Clause-37 auto-negotiation controller, MAC side: sequences PCS xmit mode and tx config word.
// Define SGMII_AN_SPEED_DECODE_EN to add registered speed / duplex / link-up decode of the partner word.
`ifndef cXmitCONFIG
`define cXmitCONFIG 3'b001
`endif
`ifndef cXmitIDLE
`define cXmitIDLE 3'b010
`endif
`ifndef cXmitDATA
`define cXmitDATA 3'b100
`endif

module sgmii_an_ctrl #(
  parameter int unsigned pLinkTimer = 200000,
  parameter logic [15:0] pTxAbility = 16'h0001,
  parameter int unsigned pMatchCnt  = 3
) (
  input  logic           i_Clk,
  input  logic           i_ARst_L,
  input  logic           i_AnEnable,
  input  logic           i_AnRestart,
  input  logic           i_SyncOk,
  sgmii_an_ctrl_if.master pcs,
  output logic           o_AnComplete,
  output logic [15:0]    o16_LpAbility,
  output logic [2:0]     o3_AnState
`ifdef SGMII_AN_SPEED_DECODE_EN
  ,
  output logic [1:0]     o2_Speed,
  output logic           o_Duplex,
  output logic           o_LinkUp
`endif
);

  typedef enum logic [2:0] {
    AN_ENABLE      = 3'd0,
    AN_RESTART     = 3'd1,
    ABILITY_DETECT = 3'd2,
    ACK_DETECT     = 3'd3,
    COMPLETE_ACK   = 3'd4,
    IDLE_DETECT    = 3'd5,
    LINK_OK        = 3'd6,
    DIS_LINK_OK    = 3'd7
  } an_state_e;

  localparam int          TW        = $clog2(pLinkTimer + 1);
  localparam logic [15:0] ACK_BIT   = 16'h4000;
  localparam logic [15:0] TX_BASE   = pTxAbility & ~ACK_BIT;
  localparam logic [15:0] TX_ACK    = pTxAbility | ACK_BIT;
  localparam logic [2:0]  MATCH_MAX = 3'(pMatchCnt);

  an_state_e   state_q, state_d;
  logic        force_entry, enter;
  logic [TW-1:0] timer_q;
  logic [2:0]  cfg_cnt_q, idle_cnt_q;
  logic [15:0] last_word_q;
  logic        an_en_q;
  logic [2:0]  xmit_q, xmit_d;
  logic [15:0] tx_q, tx_d, lp_q, lp_d;
  logic        complete_q, complete_d;

  logic        cfg_v, idle_v, timer_done, ability_match, ack_match, idle_match;
  logic        rx_same_last, rx_differs_lp, last_same_lp, rx_zero, partner_drop;
  logic [15:0] rx_word;

  assign cfg_v   = pcs.i_RxConfigValid;
  assign idle_v  = pcs.i_RxIdleValid;
  assign rx_word = pcs.i16_RxConfigReg;

  // Bit 14 is the acknowledge flag and is excluded from every ability comparison.
  assign rx_same_last  = (rx_word & ~ACK_BIT) == (last_word_q & ~ACK_BIT);
  assign rx_differs_lp = (rx_word & ~ACK_BIT) != (lp_q & ~ACK_BIT);
  assign last_same_lp  = (last_word_q & ~ACK_BIT) == (lp_q & ~ACK_BIT);
  assign rx_zero       = cfg_v && (rx_word == '0);

  assign timer_done    = (timer_q == '0);
  assign ability_match = (cfg_cnt_q == MATCH_MAX) && (last_word_q != '0);
  assign ack_match     = ability_match && last_word_q[14];
  assign idle_match    = (idle_cnt_q == MATCH_MAX);

`ifdef SGMII_AN_SPEED_DECODE_EN
  assign partner_drop = cfg_v && lp_q[15] && !rx_word[15];
`else
  assign partner_drop = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) state_q <= AN_ENABLE;
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    else           state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    state_d     = state_q;
    force_entry = 1'b0;
    if (!i_SyncOk && state_q != DIS_LINK_OK) begin
      state_d     = AN_ENABLE;
      force_entry = 1'b1;
    end else if (i_AnRestart && i_AnEnable) begin
      state_d     = AN_RESTART;
      force_entry = 1'b1;
    end else if (an_en_q && !i_AnEnable) begin
      state_d     = DIS_LINK_OK;
      force_entry = 1'b1;
    end else begin
      case (state_q)
        AN_ENABLE:      state_d = i_AnEnable ? AN_RESTART : DIS_LINK_OK;
        AN_RESTART:     if (timer_done) state_d = ABILITY_DETECT;
        ABILITY_DETECT: if (ability_match) state_d = ACK_DETECT;
        ACK_DETECT: begin
          if (ack_match && last_same_lp)            state_d = COMPLETE_ACK;
          else if (cfg_v && (rx_differs_lp || rx_zero)) state_d = AN_ENABLE;
        end
        COMPLETE_ACK: begin
          if (timer_done)   state_d = IDLE_DETECT;
          else if (rx_zero) state_d = AN_ENABLE;
        end
        IDLE_DETECT: begin
          if (timer_done && idle_match) state_d = LINK_OK;
          else if (rx_zero)             state_d = AN_ENABLE;
        end
        LINK_OK:     if (cfg_v || partner_drop) state_d = AN_ENABLE;
        DIS_LINK_OK: if (!an_en_q && i_AnEnable) state_d = AN_ENABLE;
        default:     state_d = AN_ENABLE;
      endcase
    end
  end

  assign enter = force_entry || (state_d != state_q);

  // Link timer and match counters restart on every state entry; pulses on that cycle are discarded.
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      timer_q     <= '0;
      cfg_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      last_word_q <= '0;
      an_en_q     <= 1'b0;
    end else begin
      an_en_q <= i_AnEnable;
      if (cfg_v) last_word_q <= rx_word;

      if (enter)               timer_q <= TW'(pLinkTimer);
      else if (!timer_done)    timer_q <= timer_q - 1'b1;

      if (enter) begin
        cfg_cnt_q  <= '0;
        idle_cnt_q <= '0;
      end else if (cfg_v) begin
        if (!rx_same_last)               cfg_cnt_q <= 3'd1;
        else if (cfg_cnt_q != MATCH_MAX) cfg_cnt_q <= cfg_cnt_q + 3'd1;
        idle_cnt_q <= '0;
      end else if (idle_v) begin
        if (idle_cnt_q != MATCH_MAX) idle_cnt_q <= idle_cnt_q + 3'd1;
        cfg_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    xmit_d     = `cXmitCONFIG;
    tx_d       = '0;
    complete_d = 1'b0;
    case (state_q)
      ABILITY_DETECT:           tx_d = TX_BASE;
      ACK_DETECT, COMPLETE_ACK: tx_d = TX_ACK;
      IDLE_DETECT: begin
        xmit_d = `cXmitIDLE;
        tx_d   = TX_ACK;
      end
      LINK_OK: begin
        xmit_d     = `cXmitDATA;
        tx_d       = TX_ACK;
        complete_d = 1'b1;
      end
      DIS_LINK_OK: begin
        xmit_d     = `cXmitDATA;
        complete_d = 1'b1;
      end
      default: ;
    endcase

    lp_d = lp_q;
    if (state_q == DIS_LINK_OK)                                 lp_d = '0;
    else if (state_q == ABILITY_DETECT && state_d == ACK_DETECT) lp_d = last_word_q;
  end

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      xmit_q     <= `cXmitCONFIG;
      tx_q       <= '0;
      complete_q <= 1'b0;
      lp_q       <= '0;
`ifdef SGMII_AN_SPEED_DECODE_EN
      o2_Speed   <= '0;
      o_Duplex   <= 1'b0;
      o_LinkUp   <= 1'b0;
`endif
    end else begin
      xmit_q     <= xmit_d;
      tx_q       <= tx_d;
      complete_q <= complete_d;
      lp_q       <= lp_d;
`ifdef SGMII_AN_SPEED_DECODE_EN
      o2_Speed   <= lp_d[11:10];
      o_Duplex   <= lp_d[12];
      o_LinkUp   <= lp_d[15] && complete_d;
`endif
    end
  end

  assign pcs.o3_Xmit         = xmit_q;
  assign pcs.o16_TxConfigReg = tx_q;
  assign o_AnComplete        = complete_q;
  assign o16_LpAbility       = lp_q;
  assign o3_AnState          = state_q;

endmodule

// File: tb/tb_sgmii_an_ctrl.sv
// Bench for sgmii_an_ctrl: directed negotiation scenarios plus randomized partner traffic,
// checked every cycle against an event-history reference model of the negotiation rules.
`ifndef cXmitCONFIG
`define cXmitCONFIG 3'b001
`endif
`ifndef cXmitIDLE
`define cXmitIDLE 3'b010
`endif
`ifndef cXmitDATA
`define cXmitDATA 3'b100
`endif

module tb_sgmii_an_ctrl;
  localparam int          LT  = 16;
  localparam int          MC  = 3;
  localparam logic [15:0] TXA = 16'h0001;
  localparam logic [15:0] MSK = 16'hBFFF;

  logic clk = 1'b0;
  logic rst_l, an_en, restart, sync_ok;
  logic [2:0]  an_state;
  logic        complete;
  logic [15:0] lp;
`ifdef SGMII_AN_SPEED_DECODE_EN
  logic [1:0]  speed;
  logic        duplex, link_up;
`endif

  always #5 clk = ~clk;

  sgmii_an_ctrl_if pcs ();

  sgmii_an_ctrl #(.pLinkTimer(LT), .pTxAbility(TXA), .pMatchCnt(MC)) dut (
    .i_Clk         (clk),
    .i_ARst_L      (rst_l),
    .i_AnEnable    (an_en),
    .i_AnRestart   (restart),
    .i_SyncOk      (sync_ok),
    .pcs           (pcs),
    .o_AnComplete  (complete),
    .o16_LpAbility (lp),
    .o3_AnState    (an_state)
`ifdef SGMII_AN_SPEED_DECODE_EN
    ,
    .o2_Speed      (speed),
    .o_Duplex      (duplex),
    .o_LinkUp      (link_up)
`endif
  );

  // Reference model: history of receptions since the last state entry, time spent in state.
  typedef struct packed { logic is_cfg; logic [15:0] w; } rx_ev_t;
  rx_ev_t      hist[$];
  int          m_state, m_elapsed;
  logic        m_prev_en;
  logic [15:0] m_lp;
  logic [2:0]  e_xmit;
  logic [15:0] e_tx;
  logic        e_comp, e_duplex, e_link_up;
  logic [1:0]  e_speed;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int cfg_run();
    int  n = 0;
    bit  go = 1;
    if (hist.size() == 0 || !hist[hist.size()-1].is_cfg) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (go && hist[i].is_cfg && ((hist[i].w & MSK) == (hist[hist.size()-1].w & MSK))) n++;
      else go = 0;
    end
    return n;
  endfunction

  function automatic int idle_run();
    int n = 0;
    bit go = 1;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (go && !hist[i].is_cfg) n++;
      else go = 0;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_state = 0; m_elapsed = LT; hist.delete(); m_prev_en = 1'b0; m_lp = '0;
    e_xmit = `cXmitCONFIG; e_tx = '0; e_comp = 1'b0;
    e_speed = '0; e_duplex = 1'b0; e_link_up = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic        cv, iv, ability, ack, idle_m, tdone, forced;
    logic [15:0] w, last, lp_n;
    int          nxt;
    rx_ev_t      ev;
    cv = pcs.i_RxConfigValid; iv = pcs.i_RxIdleValid; w = pcs.i16_RxConfigReg;
    last    = (hist.size() != 0) ? hist[hist.size()-1].w : 16'h0;
    ability = (cfg_run() >= MC) && (last != 0);
    ack     = ability && last[14];
    idle_m  = idle_run() >= MC;
    tdone   = m_elapsed >= LT;
    nxt = m_state; forced = 1'b0;
    if (!sync_ok && m_state != 7)        begin nxt = 0; forced = 1'b1; end
    else if (restart && an_en)           begin nxt = 1; forced = 1'b1; end
    else if (m_prev_en && !an_en)        begin nxt = 7; forced = 1'b1; end
    else begin
      case (m_state)
        0: nxt = an_en ? 1 : 7;
        1: if (tdone) nxt = 2;
        2: if (ability) nxt = 3;
        3: if (ack && ((last & MSK) == (m_lp & MSK))) nxt = 4;
           else if (cv && (((w & MSK) != (m_lp & MSK)) || w == 0)) nxt = 0;
        4: if (tdone) nxt = 5; else if (cv && w == 0) nxt = 0;
        5: if (tdone && idle_m) nxt = 6; else if (cv && w == 0) nxt = 0;
        6: if (cv) nxt = 0;
        default: if (!m_prev_en && an_en) nxt = 0;
      endcase
    end
    case (m_state)
      2:       begin e_xmit = `cXmitCONFIG; e_tx = TXA & MSK;      e_comp = 1'b0; end
      3, 4:    begin e_xmit = `cXmitCONFIG; e_tx = TXA | 16'h4000; e_comp = 1'b0; end
      5:       begin e_xmit = `cXmitIDLE;   e_tx = TXA | 16'h4000; e_comp = 1'b0; end
      6:       begin e_xmit = `cXmitDATA;   e_tx = TXA | 16'h4000; e_comp = 1'b1; end
      7:       begin e_xmit = `cXmitDATA;   e_tx = 16'h0;          e_comp = 1'b1; end
      default: begin e_xmit = `cXmitCONFIG; e_tx = 16'h0;          e_comp = 1'b0; end
    endcase
    if (m_state == 7)                lp_n = 16'h0;
    else if (m_state == 2 && nxt == 3) lp_n = last;
    else                             lp_n = m_lp;
    m_lp = lp_n;
    e_speed = lp_n[11:10]; e_duplex = lp_n[12]; e_link_up = lp_n[15] && e_comp;
    if (forced || nxt != m_state) begin
      m_elapsed = 0;
      hist.delete();
    end else begin
      if (m_elapsed < LT) m_elapsed++;
      if (cv)      begin ev.is_cfg = 1'b1; ev.w = w;     hist.push_back(ev); end
      else if (iv) begin ev.is_cfg = 1'b0; ev.w = 16'h0; hist.push_back(ev); end
      if (hist.size() > 8) void'(hist.pop_front());
    end
    m_prev_en = an_en;
    m_state   = nxt;
  endtask

  task automatic compare_all();
    check("an_state", 32'(an_state), 32'(m_state));
    check("xmit", 32'(pcs.o3_Xmit), 32'(e_xmit));
    check("tx_cfg", 32'(pcs.o16_TxConfigReg), 32'(e_tx));
    check("an_complete", 32'(complete), 32'(e_comp));
    check("lp_ability", 32'(lp), 32'(m_lp));
`ifdef SGMII_AN_SPEED_DECODE_EN
    check("speed", 32'(speed), 32'(e_speed));
    check("duplex", 32'(duplex), 32'(e_duplex));
    check("link_up", 32'(link_up), 32'(e_link_up));
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_cfg(input logic [15:0] w);
    pcs.i16_RxConfigReg = w;
    pcs.i_RxConfigValid = 1'b1;
    cycle();
    pcs.i_RxConfigValid = 1'b0;
  endtask

  task automatic send_idle();
    pcs.i_RxIdleValid = 1'b1;
    cycle();
    pcs.i_RxIdleValid = 1'b0;
  endtask

  task automatic run_until(input int tgt, input int budget);
    int k = 0;
    while (m_state != tgt && k < budget) begin
      cycle();
      k++;
    end
    check($sformatf("reach_state_%0d", tgt), 32'(an_state), 32'(tgt));
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  logic [15:0] word_tab [6];
  int          mode;

  initial begin
    word_tab = '{16'h0001, 16'h4001, 16'h0000, 16'h4021, 16'hD801, 16'h5801};
    rst_l = 1'b0; an_en = 1'b1; restart = 1'b0; sync_ok = 1'b1;
    pcs.i_RxConfigValid = 1'b0; pcs.i16_RxConfigReg = '0; pcs.i_RxIdleValid = 1'b0;

    // Full negotiation with a matching partner.
    do_reset();
    check("rst_xmit", 32'(pcs.o3_Xmit), 32'(`cXmitCONFIG));
    check("rst_tx", 32'(pcs.o16_TxConfigReg), 32'h0);
    run_until(2, 100);
    check("tx_before_ability", 32'(pcs.o16_TxConfigReg), 32'h0);
    repeat (3) send_cfg(16'h0001);
    check("tx_ability", 32'(pcs.o16_TxConfigReg), 32'h0001);
    wait_cycles(1);
    check("enter_ack", 32'(an_state), 32'd3);
    wait_cycles(1);
    check("tx_ack", 32'(pcs.o16_TxConfigReg), 32'h4001);
    repeat (3) send_cfg(16'h4001);
    wait_cycles(1);
    check("enter_complete_ack", 32'(an_state), 32'd4);
    run_until(5, 40);
    wait_cycles(1);
    check("xmit_idle", 32'(pcs.o3_Xmit), 32'(`cXmitIDLE));
    repeat (3) send_idle();
    run_until(6, 40);
    wait_cycles(1);
    check("xmit_data", 32'(pcs.o3_Xmit), 32'(`cXmitDATA));
    check("complete_set", 32'(complete), 32'h1);
    check("lp_latched", 32'(lp), 32'h0001);

    // Loss of sync in LINK_OK.
    sync_ok = 1'b0;
    wait_cycles(1);
    sync_ok = 1'b1;
    wait_cycles(1);
    check("sync_drop_complete", 32'(complete), 32'h0);
    check("sync_drop_xmit", 32'(pcs.o3_Xmit), 32'(`cXmitCONFIG));
    check("sync_drop_tx", 32'(pcs.o16_TxConfigReg), 32'h0);

    // An /I/ breaks the run of identical /C/ words.
    run_until(2, 100);
    send_cfg(16'h0001); send_cfg(16'h0001); send_idle(); send_cfg(16'h0001);
    wait_cycles(3);
    check("no_ability_match", 32'(an_state), 32'd2);

    // Mismatching word in ACK_DETECT restarts negotiation.
    repeat (2) send_cfg(16'h0001);
    wait_cycles(1);
    check("ack_entered", 32'(an_state), 32'd3);
    send_cfg(16'h4021);
    check("ack_mismatch_restart", 32'(an_state), 32'd0);
    wait_cycles(1);
    check("after_mismatch_state", 32'(an_state), 32'd1);
    check("after_mismatch_complete", 32'(complete), 32'h0);

    // Auto-negotiation disabled from reset; restart pulse ignored.
    an_en = 1'b0;
    do_reset();
    wait_cycles(2);
    check("dis_state", 32'(an_state), 32'd7);
    check("dis_xmit", 32'(pcs.o3_Xmit), 32'(`cXmitDATA));
    check("dis_complete", 32'(complete), 32'h1);
    restart = 1'b1;
    wait_cycles(1);
    restart = 1'b0;
    check("dis_restart_ignored", 32'(an_state), 32'd7);
    wait_cycles(1);
    check("dis_lp_zero", 32'(lp), 32'h0);

    // Re-enable and negotiate with an SGMII-style partner word.
    an_en = 1'b1;
    wait_cycles(1);
    check("reenable", 32'(an_state), 32'd0);
    run_until(2, 100);
    repeat (3) send_cfg(16'hD801);
    wait_cycles(1);
    repeat (3) send_cfg(16'hD801);
    wait_cycles(1);
    run_until(5, 40);
    repeat (3) send_idle();
    run_until(6, 40);
    wait_cycles(1);
    check("lp_d801", 32'(lp), 32'hD801);
`ifdef SGMII_AN_SPEED_DECODE_EN
    check("speed_decode", 32'(speed), 32'h2);
    check("duplex_decode", 32'(duplex), 32'h1);
    check("link_up_decode", 32'(link_up), 32'h1);
`endif
    send_cfg(16'h5801);
    check("bit15_drop_restart", 32'(an_state), 32'd0);

    // Randomized partner traffic with occasional sync loss, restarts and enable toggles.
    mode = 0;
    for (int c = 0; c < 15000; c++) begin
      if (c % 24 == 0) mode = int'($urandom_range(0, 5));
      pcs.i_RxConfigValid = 1'b0;
      pcs.i_RxIdleValid   = 1'b0;
      restart = ($urandom_range(0, 699) == 0);
      sync_ok = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 1499) == 0) an_en = ~an_en;
      if ($urandom_range(0, 1) == 1) begin
        case (mode)
          0: begin pcs.i_RxConfigValid = 1'b1; pcs.i16_RxConfigReg = 16'h0001; end
          1: begin pcs.i_RxConfigValid = 1'b1; pcs.i16_RxConfigReg = 16'h4001; end
          2, 3: pcs.i_RxIdleValid = 1'b1;
          4: begin
            pcs.i_RxConfigValid = 1'b1;
            pcs.i16_RxConfigReg = word_tab[$urandom_range(0, 5)];
            pcs.i_RxIdleValid   = ($urandom_range(0, 3) == 0);
          end
          default: ;
        endcase
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
